// File: rtl/nasti_stream_req_gen_if.sv
// nasti_stream_req_gen_if
// Groups the job-side handshake and the mover-side request channel used by
// nasti_stream_req_gen.
//   job_*   : job offer (valid/ready handshake) carrying address, length, tags
//   r_*     : chunk request to the data mover; r_ready is the completion pulse
//   busy/done/err : status (done/err are one-cycle pulses)
// Modports: master = request generator, slave = job source / mover side.
interface nasti_stream_req_gen_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DEST_WIDTH = 1,
    parameter int USER_WIDTH = 1
);
    logic                  job_valid;
    logic                  job_ready;
    logic [ADDR_WIDTH-1:0] job_addr;
    logic [ADDR_WIDTH-1:0] job_len;
    logic [DEST_WIDTH-1:0] job_dest;
    logic [USER_WIDTH-1:0] job_user;
    logic                  job_last;

    logic                  r_valid;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_len;
    logic [DEST_WIDTH-1:0] r_dest;
    logic [USER_WIDTH-1:0] r_user;
    logic                  r_last;
    logic                  r_ready;

    logic                  busy;
    logic                  done;
    logic                  err;

    modport master (
        input  job_valid, job_addr, job_len, job_dest, job_user, job_last,
        output job_ready,
        output r_valid, r_addr, r_len, r_dest, r_user, r_last,
        input  r_ready,
        output busy, done, err
    );

    modport slave (
        output job_valid, job_addr, job_len, job_dest, job_user, job_last,
        input  job_ready,
        input  r_valid, r_addr, r_len, r_dest, r_user, r_last,
        output r_ready,
        input  busy, done, err
    );
endinterface

// File: rtl/nasti_stream_req_gen.sv
// nasti_stream_req_gen
// Splits a byte-addressed job (addr, len) into mover requests that never cross
// a CHUNK_BYTES boundary. One request is outstanding at a time; the mover
// signals completion with a single-cycle r_ready while r_valid is high.
// Ports:
//   aclk, aresetn : clock, synchronous active-low reset
//   bus (master)  : job handshake in, chunk request out, busy/done/err status
module nasti_stream_req_gen #(
    parameter int ADDR_WIDTH  = 64,
    parameter int DATA_WIDTH  = 64,
    parameter int DEST_WIDTH  = 1,
    parameter int USER_WIDTH  = 1,
    parameter int CHUNK_BYTES = 4096
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    nasti_stream_req_gen_if.master  bus
);
    localparam int BEAT = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] BEAT_MASK = ADDR_WIDTH'(BEAT - 1);
    localparam logic [ADDR_WIDTH-1:0] CHUNK     = ADDR_WIDTH'(CHUNK_BYTES);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_REQ} state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_cur_addr;
    logic [ADDR_WIDTH-1:0] r_rem;
    logic                  r_job_last;
    logic [DEST_WIDTH-1:0] r_dest;
    logic [USER_WIDTH-1:0] r_user;
    logic                  r_valid;
    logic [ADDR_WIDTH-1:0] r_req_addr;
    logic [ADDR_WIDTH-1:0] r_req_len;
    logic                  r_req_last;
    logic                  r_done;
    logic                  r_err;

    logic                  w_job_bad;
    logic [ADDR_WIDTH-1:0] w_room;
    logic [ADDR_WIDTH-1:0] w_chunk;

    // Zero length or a length/address that is not beat aligned is rejected.
    assign w_job_bad = (bus.job_len == '0) ||
                       ((bus.job_addr & BEAT_MASK) != '0) ||
                       ((bus.job_len  & BEAT_MASK) != '0);

    // Bytes left before the next chunk boundary (CHUNK is a power of two).
    assign w_room  = CHUNK - (r_cur_addr & (CHUNK - 1'b1));
    assign w_chunk = (r_rem < w_room) ? r_rem : w_room;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state    <= S_IDLE;
            r_cur_addr <= '0;
            r_rem      <= '0;
            r_job_last <= 1'b0;
            r_dest     <= '0;
            r_user     <= '0;
            r_valid    <= 1'b0;
            r_req_addr <= '0;
            r_req_len  <= '0;
            r_req_last <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.job_valid) begin
                        if (w_job_bad) begin
                            r_err <= 1'b1;
                        end else begin
                            r_cur_addr <= bus.job_addr;
                            r_rem      <= bus.job_len;
                            r_dest     <= bus.job_dest;
                            r_user     <= bus.job_user;
                            r_job_last <= bus.job_last;
                            r_state    <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_req_addr <= r_cur_addr;
                    r_req_len  <= w_chunk;
                    r_req_last <= r_job_last && (w_chunk == r_rem);
                    r_valid    <= 1'b1;
                    r_state    <= S_REQ;
                end
                S_REQ: begin
                    if (bus.r_ready) begin
                        r_valid    <= 1'b0;
                        r_cur_addr <= r_cur_addr + r_req_len;
                        r_rem      <= r_rem - r_req_len;
                        if (r_rem == r_req_len) begin
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_CALC;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.job_ready = (r_state == S_IDLE);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.r_valid   = r_valid;
    assign bus.r_addr    = r_req_addr;
    assign bus.r_len     = r_req_len;
    assign bus.r_dest    = r_dest;
    assign bus.r_user    = r_user;
    assign bus.r_last    = r_req_last;
    assign bus.done      = r_done;
    assign bus.err       = r_err;
endmodule

// File: tb/tb_nasti_stream_req_gen.sv
// tb_nasti_stream_req_gen
// Directed scenarios plus randomized jobs, checked against a chunk-list
// reference computed directly from the splitting rule.
module tb_nasti_stream_req_gen;
    localparam int AW = 64;

    logic aclk;
    logic aresetn;
    int   n_chk  = 0;
    int   n_fail = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [AW-1:0] len;
        logic          last;
    } chunk_t;

    chunk_t exp_q[$];

    nasti_stream_req_gen_if #(.ADDR_WIDTH(AW), .DEST_WIDTH(1), .USER_WIDTH(1)) bus ();

    nasti_stream_req_gen #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(64), .DEST_WIDTH(1), .USER_WIDTH(1), .CHUNK_BYTES(4096)
    ) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference split: walk the job, cutting at every 4 KiB boundary.
    task automatic build_model(input logic [AW-1:0] a, input logic [AW-1:0] l, input logic last);
        logic [AW-1:0] rem, room, c;
        chunk_t e;
        exp_q.delete();
        rem = l;
        while (rem != 0) begin
            room = 64'd4096 - (a % 64'd4096);
            c = (rem < room) ? rem : room;
            e.addr = a;
            e.len  = c;
            e.last = last && (c == rem);
            exp_q.push_back(e);
            a   = a + c;
            rem = rem - c;
        end
    endtask

    task automatic offer(input logic [AW-1:0] a, input logic [AW-1:0] l, input logic last);
        @(negedge aclk);
        bus.job_valid = 1'b1;
        bus.job_addr  = a;
        bus.job_len   = l;
        bus.job_dest  = 1'b1;
        bus.job_user  = 1'b0;
        bus.job_last  = last;
        @(negedge aclk);
        bus.job_valid = 1'b0;
    endtask

    // Runs a valid job; hold < 0 picks a random r_ready delay per chunk.
    // noise enables r_ready pulses during CALC and job_* scrambling mid-job.
    task automatic run_job(input logic [AW-1:0] a, input logic [AW-1:0] l, input logic last,
                           input int hold, input bit noise);
        int k;
        build_model(a, l, last);
        offer(a, l, last);
        chk("calc_valid_low", 64'(bus.r_valid), 64'd0);
        chk("busy_after_accept", 64'(bus.busy), 64'd1);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge aclk);
            bus.r_ready = 1'b0;
            chk("r_valid", 64'(bus.r_valid), 64'd1);
            chk("r_addr", bus.r_addr, exp_q[i].addr);
            chk("r_len", bus.r_len, exp_q[i].len);
            chk("r_last", 64'(bus.r_last), 64'(exp_q[i].last));
            chk("r_dest", 64'(bus.r_dest), 64'd1);
            k = (hold < 0) ? int'($urandom_range(0, 3)) : hold;
            for (int j = 0; j < k; j++) begin
                if (noise) begin
                    bus.job_addr = {$urandom, $urandom};
                    bus.job_len  = {$urandom, $urandom};
                    bus.job_last = ~bus.job_last;
                    bus.job_dest = ~bus.job_dest;
                end
                @(negedge aclk);
                chk("hold_valid", 64'(bus.r_valid), 64'd1);
                chk("hold_addr", bus.r_addr, exp_q[i].addr);
                chk("hold_len", bus.r_len, exp_q[i].len);
            end
            bus.r_ready = 1'b1;
            @(negedge aclk);
            bus.r_ready = 1'b0;
            chk("valid_drop", 64'(bus.r_valid), 64'd0);
            if (i == exp_q.size() - 1) begin
                chk("done", 64'(bus.done), 64'd1);
                chk("idle_ready", 64'(bus.job_ready), 64'd1);
                chk("idle_busy", 64'(bus.busy), 64'd0);
            end else begin
                chk("no_done", 64'(bus.done), 64'd0);
                if (noise) bus.r_ready = 1'b1; // lands on CALC, must be ignored
            end
        end
        if (noise) bus.r_ready = 1'b1; // lands on IDLE, must be ignored
        @(negedge aclk);
        bus.r_ready = 1'b0;
        chk("done_one_cycle", 64'(bus.done), 64'd0);
        chk("idle_valid", 64'(bus.r_valid), 64'd0);
    endtask

    task automatic bad_job(input logic [AW-1:0] a, input logic [AW-1:0] l);
        offer(a, l, 1'b1);
        chk("err_pulse", 64'(bus.err), 64'd1);
        chk("err_no_valid", 64'(bus.r_valid), 64'd0);
        chk("err_ready", 64'(bus.job_ready), 64'd1);
        @(negedge aclk);
        chk("err_cleared", 64'(bus.err), 64'd0);
        chk("err_still_no_valid", 64'(bus.r_valid), 64'd0);
        chk("err_idle", 64'(bus.busy), 64'd0);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_valid"}, 64'(bus.r_valid), 64'd0);
        chk({tag, "_done"}, 64'(bus.done), 64'd0);
        chk({tag, "_err"}, 64'(bus.err), 64'd0);
        chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
        chk({tag, "_ready"}, 64'(bus.job_ready), 64'd1);
        chk({tag, "_addr"}, bus.r_addr, 64'd0);
        chk({tag, "_len"}, bus.r_len, 64'd0);
        chk({tag, "_last"}, 64'(bus.r_last), 64'd0);
    endtask

    initial begin
        logic [AW-1:0] a, l;
        aresetn       = 1'b0;
        bus.job_valid = 1'b0;
        bus.job_addr  = '0;
        bus.job_len   = '0;
        bus.job_dest  = 1'b0;
        bus.job_user  = 1'b0;
        bus.job_last  = 1'b0;
        bus.r_ready   = 1'b0;
        repeat (3) @(negedge aclk);
        check_reset_state("rst");
        aresetn = 1'b1;

        run_job(64'h1000, 64'h40, 1'b1, 3, 1'b0);
        run_job(64'h0FC0, 64'h2080, 1'b1, -1, 1'b0);
        run_job(64'h2000, 64'h1000, 1'b0, 0, 1'b0);
        bad_job(64'h1004, 64'h40);
        bad_job(64'h1000, 64'h0);
        bad_job(64'h1000, 64'h44);
        run_job(64'hFFFF_FFFF_FFFF_FFC0, 64'h80, 1'b1, -1, 1'b0);

        // Reset while a request is outstanding.
        build_model(64'h3000, 64'h2000, 1'b1);
        offer(64'h3000, 64'h2000, 1'b1);
        @(negedge aclk);
        chk("pre_rst_valid", 64'(bus.r_valid), 64'd1);
        aresetn = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        check_reset_state("mid_rst");
        @(negedge aclk);
        chk("mid_rst_no_done", 64'(bus.done), 64'd0);
        run_job(64'h5000, 64'h100, 1'b1, -1, 1'b0);

        run_job(64'h0FF8, 64'h1010, 1'b1, -1, 1'b1);

        for (int n = 0; n < 25; n++) begin
            a = {$urandom, $urandom_range(0, 32'h7FFF) & 32'hFFF8};
            l = 64'($urandom_range(1, 32'h600)) * 64'd8;
            if ($urandom_range(0, 9) == 0) bad_job(a | 64'd4, l);
            else run_job(a, l, 1'($urandom), -1, 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/nasti_stream_req_gen.md
NASTI_STREAM_REQ_GEN -- requirements
Module: nasti_stream_req_gen

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- ADDR_WIDTH, 64, address/length width
- DATA_WIDTH, 64, mover data width; BEAT = DATA_WIDTH/8 bytes
- DEST_WIDTH, 1, stream dest width
- USER_WIDTH, 1, stream user width
- CHUNK_BYTES, 4096, split boundary; power of two, multiple of BEAT

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- aclk, in, 1, clock
- aresetn, in, 1, reset
- job_valid, in, 1, job offered
- job_ready, out, 1, job accepted when both high
- job_addr, in, ADDR_WIDTH, byte start address
- job_len, in, ADDR_WIDTH, byte length
- job_dest, in, DEST_WIDTH, dest tag
- job_user, in, USER_WIDTH, user tag
- job_last, in, 1, job ends a stream packet
- r_valid, out, 1, request to mover
- r_addr, out, ADDR_WIDTH, chunk address
- r_len, out, ADDR_WIDTH, chunk byte length
- r_dest, out, DEST_WIDTH, copy of job_dest
- r_user, out, USER_WIDTH, copy of job_user
- r_last, out, 1, packet end on this chunk
- r_ready, in, 1, mover completion pulse
- busy, out, 1, job in progress
- done, out, 1, one-cycle pulse, job complete
- err, out, 1, one-cycle pulse, job rejected

REQ-003 One clock (aclk); reset aresetn SHALL be synchronous and active-low.

Function
REQ-004 States SHALL be IDLE, CALC, REQ.
REQ-005 job_ready SHALL equal (state==IDLE); busy SHALL equal (state!=IDLE).
REQ-006 On IDLE accept, the block SHALL reject the job if job_len==0 or the low log2(BEAT) bits of job_addr or job_len are nonzero: err pulses next cycle, no request is issued, and the state stays IDLE.
REQ-007 On a valid accept, the block SHALL latch addr, remaining=job_len, dest, user and last, then go to CALC.
REQ-008 In CALC, chunk SHALL be min(remaining, CHUNK_BYTES - (addr mod CHUNK_BYTES)) and SHALL be registered into r_addr/r_len; next state REQ.
REQ-009 In REQ, r_valid SHALL be 1; r_addr, r_len, r_dest, r_user and r_last SHALL stay stable until r_valid && r_ready.
REQ-010 r_last SHALL be latched last AND (chunk == remaining).
REQ-011 On r_valid && r_ready: addr += r_len, remaining -= r_len, r_valid deasserts next cycle; if remaining becomes 0, go to IDLE with done pulsing one cycle, else go to CALC.
REQ-012 r_valid SHALL be low for at least one cycle between consecutive requests (CALC gap).
REQ-013 r_ready while r_valid==0 SHALL be ignored.
REQ-014 Latency: accept at cycle N gives r_valid high at N+2; done is high in the cycle after the final r_ready.
REQ-015 Address arithmetic SHALL wrap modulo 2^ADDR_WIDTH without error.
REQ-016 job_* inputs SHALL be sampled only at accept; later changes SHALL have no effect.

Reset
REQ-017 With aresetn low at a clock edge, next cycle state=IDLE and r_valid, done, err, busy=0; r_addr, r_len, r_last=0; job_ready=1.
REQ-018 Reset in REQ SHALL drop r_valid without waiting for r_ready; the in-flight job is discarded and no done is produced.

Verification
REQ-019 Scenarios:
- addr=0x1000, len=0x40, last=1, r_ready 3 cycles after r_valid -> one request (0x1000, 0x40, r_last=1); done 1 cycle after r_ready.
- addr=0x0FC0, len=0x2080, last=1 -> requests (0x0FC0,0x40,0), (0x1000,0x1000,0), (0x2000,0x1000,0), (0x3000,0x40,1).
- addr=0x2000, len=0x1000, last=0 -> single request, r_last=0.
- addr=0x1004 or len=0 -> err pulse, r_valid never high, job_ready back to 1 next cycle.
- Reset asserted while r_valid=1 -> r_valid=0 next cycle, no done; a new job then runs normally.
- r_ready pulsed during CALC/IDLE and job_* changed mid-job -> no effect on the request sequence.
